sprite_scheduler: RTL

Sequences the sprite blocks (ball, paddle, brick) that share the single VGA adapter write port. On each frame tick it runs every requesting client to completion in fixed order (ball, paddle, brick), giving each a one-cycle reset_state pulse followed by enable_state until the client's done. It multiplexes the granted client's x/y/colour/plot onto the VGA adapter. It sits between the game top level and the sprite blocks and replaces ad-hoc chaining of their done/enable signals.

---
 rtl/sprite_scheduler.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sprite_scheduler.sv
// sprite_scheduler: runs each requesting sprite client (ball, paddle, brick)
// to completion once per frame tick, in fixed priority order, and muxes the
// granted client's pixel stream onto the single VGA adapter write port.
module sprite_scheduler #(
  parameter int TIMEOUT = 1000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        frame_tick,
  input  logic [2:0]  req,
  input  logic [2:0]  done,
  input  logic [23:0] x_bus,
  input  logic [20:0] y_bus,
  input  logic [8:0]  colour_bus,
  input  logic [2:0]  plot_bus,
  output logic [2:0]  reset_state,
  output logic [2:0]  enable_state,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        overrun,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, SELECT, RST, RUN} state_t;

  // Last watchdog value of a run; the watchdog never passes TIMEOUT, so 10 bits suffice.
  localparam logic [9:0] WD_LAST = 10'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [2:0]  pending_reg, pending_next;
  logic [1:0]  grant_reg, grant_next;
  logic [9:0]  watchdog_reg, watchdog_next;
  logic        overrun_next, timeout_next;
  logic [2:0]  grant_mask, grant_onehot_next;

  logic [7:0]  x_slice      [3];
  logic [6:0]  y_slice      [3];
  logic [2:0]  colour_slice [3];
  logic [7:0]  x_sel;
  logic [6:0]  y_sel;
  logic [2:0]  colour_sel;
  logic        plot_sel;
  logic        done_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_slice
      assign x_slice[gi]      = x_bus[8*gi +: 8];
      assign y_slice[gi]      = y_bus[7*gi +: 7];
      assign colour_slice[gi] = colour_bus[3*gi +: 3];
    end
  endgenerate

  assign grant_mask        = 3'b001 << grant_reg;
  assign grant_onehot_next = 3'b001 << grant_next;

  // Select the granted client's done, plot and pixel data.
  always_comb begin
    x_sel      = x_slice[0];
    y_sel      = y_slice[0];
    colour_sel = colour_slice[0];
    plot_sel   = plot_bus[0];
    done_sel   = done[0];
    case (grant_reg)
      2'd1: begin
        x_sel      = x_slice[1];
        y_sel      = y_slice[1];
        colour_sel = colour_slice[1];
        plot_sel   = plot_bus[1];
        done_sel   = done[1];
      end
      2'd2: begin
        x_sel      = x_slice[2];
        y_sel      = y_slice[2];
        colour_sel = colour_slice[2];
        plot_sel   = plot_bus[2];
        done_sel   = done[2];
      end
      default: ;
    endcase
  end

  // Next-state logic: frame latch, priority grant, client restart/run, watchdog.
  always_comb begin
    state_next    = state_reg;
    pending_next  = pending_reg;
    grant_next    = grant_reg;
    watchdog_next = watchdog_reg;
    timeout_next  = timeout;
    // A tick arriving mid-frame is only flagged; the running frame carries on.
    overrun_next  = overrun | (frame_tick && (state_reg != IDLE));
    case (state_reg)
      IDLE: begin
        if (frame_tick) begin
          pending_next = req;
          state_next   = SELECT;
        end
      end
      SELECT: begin
        if (pending_reg == 3'b000) begin
          state_next = IDLE;
        end else begin
          if (pending_reg[0])      grant_next = 2'd0;
          else if (pending_reg[1]) grant_next = 2'd1;
          else                     grant_next = 2'd2;
          state_next = RST;
        end
      end
      RST: begin
        watchdog_next = '0;
        state_next    = RUN;
      end
      RUN: begin
        watchdog_next = watchdog_reg + 10'd1;
        // done has priority over a watchdog expiry in the same cycle.
        if (done_sel) begin
          pending_next = pending_reg & ~grant_mask;
          state_next   = SELECT;
        end else if (watchdog_reg == WD_LAST) begin
          timeout_next = 1'b1;
          pending_next = pending_reg & ~grant_mask;
          state_next   = SELECT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus registered control outputs derived from the next state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      pending_reg  <= '0;
      grant_reg    <= '0;
      watchdog_reg <= '0;
      overrun      <= 1'b0;
      timeout      <= 1'b0;
      reset_state  <= '0;
      enable_state <= '0;
      busy         <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pending_reg  <= pending_next;
      grant_reg    <= grant_next;
      watchdog_reg <= watchdog_next;
      overrun      <= overrun_next;
      timeout      <= timeout_next;
      reset_state  <= (state_next == RST) ? grant_onehot_next : 3'b000;
      enable_state <= (state_next == RUN) ? grant_onehot_next : 3'b000;
      busy         <= (state_next != IDLE);
    end
  end

  // VGA output register: follow the granted client while running, else hold pixel and drop plot.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
    end else if (state_reg == RUN) begin
      x      <= x_sel;
      y      <= y_sel;
      colour <= colour_sel;
      plot   <= plot_sel;
    end else begin
      plot   <= 1'b0;
    end
  end

endmodule
